// File: rtl/booth_multiplier_seq_if.sv
// Start/busy/done handshake bundle for the sequential Booth multiplier.
// The master drives the operands and start; the slave returns status and product halves.
interface booth_multiplier_seq_if #(
  parameter int REG_SIZE = 32
);
  logic                start;
  logic [REG_SIZE-1:0] Multiplicand;
  logic [REG_SIZE-1:0] Multiplier;
  logic                busy;
  logic                done;
  logic [REG_SIZE-1:0] HI;
  logic [REG_SIZE-1:0] LO;

  modport master (
    output start, Multiplicand, Multiplier,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, Multiplicand, Multiplier,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth signed multiplier for the ezRISC MUL instruction.
// Retires one Booth step per clock and delivers a 2*REG_SIZE-bit product as HI/LO.
module booth_multiplier_seq #(
  parameter int REG_SIZE = 32
) (
  input  logic                   clock,
  input  logic                   clear_n,
  booth_multiplier_seq_if.slave  bus
);

  localparam int CW = (REG_SIZE > 1) ? $clog2(REG_SIZE) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(REG_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [REG_SIZE:0]   acc;
  logic [REG_SIZE:0]   mcand;
  logic [REG_SIZE-1:0] mplier;
  logic                q_prev;
  logic [CW-1:0]       count;

  logic [REG_SIZE:0]   sum;
  logic [REG_SIZE:0]   acc_next;
  logic [REG_SIZE-1:0] mplier_next;
  logic                q_prev_next;
  logic                accept;

  assign accept = bus.start && (state == IDLE || state == DONE);

  // A and M carry one extra sign bit so subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    sum = acc;
    unique case ({mplier[0], q_prev})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    {acc_next, mplier_next, q_prev_next} = {sum[REG_SIZE], sum, mplier};
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      q_prev   <= 1'b0;
      count    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.HI   <= '0;
      bus.LO   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (accept) begin
            state    <= RUN;
            acc      <= '0;
            mcand    <= {bus.Multiplicand[REG_SIZE-1], bus.Multiplicand};
            mplier   <= bus.Multiplier;
            q_prev   <= 1'b0;
            count    <= '0;
            bus.busy <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        RUN: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          q_prev <= q_prev_next;
          count  <= count + 1'b1;
          // The last step publishes the shifted result directly, saving a cycle.
          if (count == LAST_STEP) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.HI   <= acc_next[REG_SIZE-1:0];
            bus.LO   <= mplier_next;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed and randomized bench for booth_multiplier_seq, checked against
// a plain signed-multiply reference with immediate assertions.
module tb_booth_multiplier_seq;

  localparam int REG_SIZE = 32;

  logic clock;
  logic clear_n;
  int   checks;
  int   failures;

  booth_multiplier_seq_if #(.REG_SIZE(REG_SIZE)) bus ();

  booth_multiplier_seq #(.REG_SIZE(REG_SIZE)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b);
    longint pa;
    longint pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called at posedge+1; the accept edge is the next posedge, after which operands are scrambled.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    bus.start        = 1'b1;
    bus.Multiplicand = a;
    bus.Multiplier   = b;
    @(posedge clock); #1;
    bus.start        = 1'b0;
    bus.Multiplicand = $urandom;
    bus.Multiplier   = $urandom;
  endtask

  task automatic waitDone(output int cycles, output int busyCnt);
    cycles  = 0;
    busyCnt = 0;
    while (bus.done !== 1'b1 && cycles < 100) begin
      if (bus.busy === 1'b1) busyCnt++;
      @(posedge clock); #1;
      cycles++;
    end
  endtask

  task automatic countDone(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      if (bus.done === 1'b1) pulses++;
    end
  endtask

  initial begin
    int          cyc;
    int          busyCnt;
    int          pulses;
    logic [63:0] expProd;
    logic [63:0] prevProd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] opA [5];
    logic [31:0] opB [5];

    checks   = 0;
    failures = 0;

    // Reset held with start asserted must keep everything idle.
    clear_n          = 1'b0;
    bus.start        = 1'b1;
    bus.Multiplicand = 32'd3;
    bus.Multiplier   = 32'd5;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("reset_done", {63'd0, bus.done}, 64'd0);
    checkOutput("reset_hilo", {bus.HI, bus.LO}, 64'd0);
    bus.start = 1'b0;
    clear_n   = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checkOutput("idle_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("idle_done", {63'd0, bus.done}, 64'd0);

    // 3 x 5 with latency, busy width and single-pulse checks.
    applyStimulus(32'd3, 32'd5);
    waitDone(cyc, busyCnt);
    checkOutput("lat_3x5", 64'(cyc), 64'd32);
    checkOutput("busy_3x5", 64'(busyCnt), 64'd32);
    checkOutput("done_busy_low", {63'd0, bus.busy}, 64'd0);
    checkOutput("prod_3x5", {bus.HI, bus.LO}, 64'h0000_0000_0000_000F);
    countDone(5, pulses);
    checkOutput("single_pulse", 64'(pulses), 64'd0);
    checkOutput("hold_3x5", {bus.HI, bus.LO}, 64'h0000_0000_0000_000F);

    // Directed signed and extreme operands.
    opA[0] = 32'hFFFF_FFF9; opB[0] = 32'h0000_0006;
    opA[1] = 32'h8000_0000; opB[1] = 32'h8000_0000;
    opA[2] = 32'h8000_0000; opB[2] = 32'hFFFF_FFFF;
    opA[3] = 32'h7FFF_FFFF; opB[3] = 32'h7FFF_FFFF;
    opA[4] = 32'h0000_0000; opB[4] = 32'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(opA[i], opB[i]);
      waitDone(cyc, busyCnt);
      checkOutput($sformatf("dir_lat_%0d", i), 64'(cyc), 64'd32);
      checkOutput($sformatf("dir_prod_%0d", i), {bus.HI, bus.LO}, refProduct(opA[i], opB[i]));
      @(posedge clock); #1;
    end
    checkOutput("spec_m7x6", refProduct(32'hFFFF_FFF9, 32'd6), 64'hFFFF_FFFF_FFFF_FFD6);

    // Randomized operands; previous result must hold during the next run.
    prevProd = {bus.HI, bus.LO};
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 3) a = 32'h8000_0000;
      if (i == 7) b = 32'hFFFF_FFFF;
      expProd = refProduct(a, b);
      applyStimulus(a, b);
      repeat (5) @(posedge clock);
      #1;
      checkOutput($sformatf("rnd_hold_%0d", i), {bus.HI, bus.LO}, prevProd);
      waitDone(cyc, busyCnt);
      checkOutput($sformatf("rnd_lat_%0d", i), 64'(cyc), 64'd27);
      checkOutput($sformatf("rnd_prod_%0d", i), {bus.HI, bus.LO}, expProd);
      prevProd = expProd;
      @(posedge clock); #1;
    end

    // start during RUN is ignored and operand changes do not leak in.
    applyStimulus(32'd2, 32'd2);
    repeat (9) @(posedge clock);
    #1;
    bus.start        = 1'b1;
    bus.Multiplicand = 32'd9;
    bus.Multiplier   = 32'd9;
    @(posedge clock); #1;
    bus.start        = 1'b0;
    bus.Multiplicand = $urandom;
    bus.Multiplier   = $urandom;
    waitDone(cyc, busyCnt);
    checkOutput("ign_lat", 64'(cyc), 64'd22);
    checkOutput("ign_prod", {bus.HI, bus.LO}, 64'd4);
    countDone(40, pulses);
    checkOutput("ign_no_second", 64'(pulses), 64'd0);

    // Reset mid-operation abandons the run.
    applyStimulus(32'd100, 32'd100);
    repeat (14) @(posedge clock);
    #1;
    clear_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("midrst_done", {63'd0, bus.done}, 64'd0);
    checkOutput("midrst_hilo", {bus.HI, bus.LO}, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    clear_n = 1'b1;
    countDone(40, pulses);
    checkOutput("midrst_no_done", 64'(pulses), 64'd0);
    checkOutput("midrst_idle", {63'd0, bus.busy}, 64'd0);

    // Back-to-back: start raised during the DONE cycle.
    applyStimulus(32'd4, 32'hFFFF_FFFC);
    waitDone(cyc, busyCnt);
    checkOutput("b2b_lat1", 64'(cyc), 64'd32);
    checkOutput("b2b_prod1", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFF0);
    applyStimulus(32'd10, 32'd10);
    checkOutput("b2b_busy", {63'd0, bus.busy}, 64'd1);
    checkOutput("b2b_done_low", {63'd0, bus.done}, 64'd0);
    waitDone(cyc, busyCnt);
    checkOutput("b2b_lat2", 64'(cyc), 64'd32);
    checkOutput("b2b_prod2", {bus.HI, bus.LO}, 64'h0000_0000_0000_0064);

    @(posedge clock); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
